// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with whole-line refill from backing memory.
// Latency: hit answers 1 cycle after acceptance; miss takes 1 + sum(word transfer times) + 1 cycles.
// Backpressure: core holds exIns_ren until exIns_valid; refill waits on mem_valid with mem_addr held stable.
module icache_dm #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exIns_ren,
    input  logic [31:0] exIns_addr,
    output logic        exIns_valid,
    output logic [31:0] exIns_in,
    input  logic        inv,
    output logic        mem_ren,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata
);
    localparam int OW = $clog2(WORDS);
    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - OW - IW;

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

    state_t            state;
    logic [LINES-1:0]  valid_q;
    logic [TW-1:0]     tag_q  [LINES];
    logic [31:0]       data_q [LINES][WORDS];

    logic [TW-1:0]     r_tag;
    logic [IW-1:0]     r_idx;
    logic [OW-1:0]     r_off;
    logic [OW-1:0]     k;
    logic              inv_pend;

    logic [OW-1:0]     a_off;
    logic [IW-1:0]     a_idx;
    logic [TW-1:0]     a_tag;
    logic              accept;
    logic              hit;
    logic              fill_we;
    logic              fill_last;
    logic [31:0]       fill_resp;
    logic              unused_addr_bits;

    assign a_off = exIns_addr[OW+1:2];
    assign a_idx = exIns_addr[OW+IW+1:OW+2];
    assign a_tag = exIns_addr[31:OW+IW+2];
    assign unused_addr_bits = ^exIns_addr[1:0];

    // A response cycle never accepts; inv in the accepting cycle forces a miss.
    assign accept    = (state == IDLE) && exIns_ren && !exIns_valid;
    assign hit       = valid_q[a_idx] && (tag_q[a_idx] == a_tag) && !inv;
    assign fill_we   = (state == REFILL) && mem_ren && mem_valid;
    assign fill_last = fill_we && (k == OW'(WORDS - 1));
    // On the final transfer the requested word may be the one arriving right now.
    assign fill_resp = (r_off == k) ? mem_rdata : data_q[r_idx][r_off];

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[r_idx][k] <= mem_rdata;
        end
        if (fill_last) begin
            tag_q[r_idx] <= r_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            valid_q     <= '0;
            inv_pend    <= 1'b0;
            k           <= '0;
            r_tag       <= '0;
            r_idx       <= '0;
            r_off       <= '0;
            exIns_valid <= 1'b0;
            exIns_in    <= '0;
            mem_ren     <= 1'b0;
            mem_addr    <= '0;
        end else begin
            exIns_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (inv) begin
                        valid_q <= '0;
                    end
                    if (accept) begin
                        if (hit) begin
                            exIns_valid <= 1'b1;
                            exIns_in    <= data_q[a_idx][a_off];
                        end else begin
                            r_tag <= a_tag;
                            r_idx <= a_idx;
                            r_off <= a_off;
                            k     <= '0;
                            state <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (inv) begin
                        inv_pend <= 1'b1;
                    end
                    if (!mem_ren) begin
                        mem_ren  <= 1'b1;
                        mem_addr <= {r_tag, r_idx, k, 2'b00};
                    end else if (mem_valid) begin
                        k        <= k + OW'(1);
                        mem_addr <= {r_tag, r_idx, k + OW'(1), 2'b00};
                        if (fill_last) begin
                            mem_ren     <= 1'b0;
                            state       <= RESP;
                            exIns_valid <= 1'b1;
                            exIns_in    <= fill_resp;
                            inv_pend    <= 1'b0;
                            if (inv_pend || inv) begin
                                valid_q <= '0;
                            end else begin
                                valid_q[r_idx] <= 1'b1;
                            end
                        end
                    end
                end
                RESP: begin
                    if (inv) begin
                        valid_q <= '0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus randomized fetches against a line-level model.
`timescale 1ns/1ps
module tb_icache_dm;
    logic        clk;
    logic        rst;
    logic        exIns_ren;
    logic [31:0] exIns_addr;
    logic        exIns_valid;
    logic [31:0] exIns_in;
    logic        inv;
    logic        mem_ren;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    // memory responder controls
    int          max_dly = 0;
    logic [31:0] salt = 0;
    bit          chk_stable = 0;
    bit          force_vld = 0;

    logic [31:0] xfer_q[$];
    time         last_xfer_t = 0;
    time         valid_t = 0;

    // reference model: per-line valid flag and tag
    bit          m_valid[16];
    int          m_tag[16];

    icache_dm #(.LINES(16), .WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .exIns_ren(exIns_ren), .exIns_addr(exIns_addr),
        .exIns_valid(exIns_valid), .exIns_in(exIns_in),
        .inv(inv),
        .mem_ren(mem_ren), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Memory: word at address A reads as A ^ salt, with a random per-word delay.
    initial begin
        int          dly;
        bit          armed;
        logic        prev_ren;
        logic        prev_vld;
        logic [31:0] prev_addr;
        dly = 0; armed = 0; prev_ren = 0; prev_vld = 0; prev_addr = 0;
        mem_valid = 0;
        mem_rdata = 0;
        forever begin
            @(negedge clk);
            if (chk_stable && prev_ren && !prev_vld && mem_ren && !rst) begin
                checks++;
                if (mem_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL mem_addr_stable: got %h, expected %h", mem_addr, prev_addr);
                end
            end
            mem_valid = 0;
            if (force_vld) begin
                mem_valid = 1;
                mem_rdata = 32'hDEAD_BEEF;
            end else if (mem_ren) begin
                if (!armed) begin
                    dly = $urandom_range(0, max_dly);
                    armed = 1;
                end
                if (dly == 0) begin
                    mem_valid = 1;
                    mem_rdata = mem_addr ^ salt;
                    armed = 0;
                end else begin
                    dly--;
                end
            end else begin
                armed = 0;
            end
            prev_ren = mem_ren;
            prev_vld = mem_valid;
            prev_addr = mem_addr;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (!rst && mem_ren && mem_valid) begin
                xfer_q.push_back(mem_addr);
                last_xfer_t = $time;
            end
        end
    end

    // Present one fetch and wait (bounded) for the response.
    // inv_cyc: -1 none, 0 with the request, n>0 for one cycle n cycles after acceptance.
    task automatic fetch(input logic [31:0] a, input int inv_cyc,
                         output logic [31:0] d, output int lat, output int nx, output bit ok);
        xfer_q.delete();
        @(negedge clk);
        exIns_ren = 1;
        exIns_addr = a;
        inv = (inv_cyc == 0);
        lat = 0;
        d = 0;
        ok = 0;
        while (!ok && lat < 300) begin
            @(negedge clk);
            lat++;
            inv = (inv_cyc > 0 && lat == inv_cyc);
            if (exIns_valid) begin
                ok = 1;
                d = exIns_in;
                valid_t = $time;
            end
        end
        exIns_ren = 0;
        inv = 0;
        nx = xfer_q.size();
    endtask

    task automatic apply_reset();
        rst = 1;
        exIns_ren = 0;
        inv = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
    endtask

    task automatic test_reset();
        rst = 1; exIns_ren = 0; exIns_addr = 0; inv = 0;
        repeat (2) @(negedge clk);
        checks++; if (exIns_valid !== 1'b0) begin errors++; $display("FAIL reset_exIns_valid: got %b, expected 0", exIns_valid); end
        checks++; if (exIns_in !== 32'h0) begin errors++; $display("FAIL reset_exIns_in: got %h, expected 0", exIns_in); end
        checks++; if (mem_ren !== 1'b0) begin errors++; $display("FAIL reset_mem_ren: got %b, expected 0", mem_ren); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h, expected 0", mem_addr); end
        rst = 0;
    endtask

    task automatic test_cold_miss();
        logic [31:0] d; int lat, nx; bit ok;
        max_dly = 0; salt = 0;
        fetch(32'h104, -1, d, lat, nx, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cold_timeout: got no exIns_valid, expected response"); end
        checks++; if (nx != 4) begin errors++; $display("FAIL cold_xfer_count: got %0d, expected 4", nx); end
        if (nx == 4)
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (xfer_q[i] !== 32'h100 + 4*i) begin errors++; $display("FAIL cold_mem_addr%0d: got %h, expected %h", i, xfer_q[i], 32'h100 + 4*i); end
            end
        checks++; if (d !== 32'h104) begin errors++; $display("FAIL cold_data: got %h, expected 00000104", d); end
        checks++; if (lat != 6) begin errors++; $display("FAIL cold_latency: got %0d, expected 6", lat); end
        checks++; if (valid_t - last_xfer_t != 5) begin errors++; $display("FAIL cold_resp_gap: got %0t, expected 5", valid_t - last_xfer_t); end
    endtask

    task automatic test_hit();
        logic [31:0] d; int lat, nx; bit ok;
        logic [31:0] addrs [2];
        addrs[0] = 32'h108; addrs[1] = 32'h10C;
        for (int i = 0; i < 2; i++) begin
            fetch(addrs[i], -1, d, lat, nx, ok);
            checks++; if (d !== addrs[i]) begin errors++; $display("FAIL hit_data%0d: got %h, expected %h", i, d, addrs[i]); end
            checks++; if (lat != 1) begin errors++; $display("FAIL hit_latency%0d: got %0d, expected 1", i, lat); end
            checks++; if (nx != 0) begin errors++; $display("FAIL hit_no_mem%0d: got %0d transfers, expected 0", i, nx); end
        end
    endtask

    task automatic test_conflict();
        logic [31:0] d; int lat, nx; bit ok;
        fetch(32'h504, -1, d, lat, nx, ok);
        checks++; if (d !== 32'h504) begin errors++; $display("FAIL evict_data: got %h, expected 00000504", d); end
        checks++; if (nx != 4) begin errors++; $display("FAIL evict_xfer_count: got %0d, expected 4", nx); end
        if (nx == 4) begin
            checks++; if (xfer_q[0] !== 32'h500 || xfer_q[3] !== 32'h50C) begin errors++; $display("FAIL evict_mem_addr: got %h..%h, expected 00000500..0000050c", xfer_q[0], xfer_q[3]); end
        end
        fetch(32'h104, -1, d, lat, nx, ok);
        checks++; if (nx != 4) begin errors++; $display("FAIL evict_refetch_miss: got %0d transfers, expected 4", nx); end
        checks++; if (d !== 32'h104) begin errors++; $display("FAIL evict_refetch_data: got %h, expected 00000104", d); end
    endtask

    task automatic test_inv();
        logic [31:0] d; int lat, nx; bit ok;
        @(negedge clk); inv = 1;
        @(negedge clk); inv = 0;
        fetch(32'h108, -1, d, lat, nx, ok);
        checks++; if (nx != 4) begin errors++; $display("FAIL inv_idle_miss: got %0d transfers, expected 4", nx); end
        checks++; if (d !== 32'h108) begin errors++; $display("FAIL inv_idle_data: got %h, expected 00000108", d); end
        // inv in the accepting cycle turns a would-be hit into a miss
        fetch(32'h108, 0, d, lat, nx, ok);
        checks++; if (nx != 4) begin errors++; $display("FAIL inv_accept_miss: got %0d transfers, expected 4", nx); end
        // inv during refill: word still returned, nothing left valid
        fetch(32'h214, 2, d, lat, nx, ok);
        checks++; if (d !== 32'h214) begin errors++; $display("FAIL inv_refill_data: got %h, expected 00000214", d); end
        fetch(32'h214, -1, d, lat, nx, ok);
        checks++; if (nx != 4) begin errors++; $display("FAIL inv_refill_line_invalid: got %0d transfers, expected 4", nx); end
        fetch(32'h104, -1, d, lat, nx, ok);
        checks++; if (nx != 4) begin errors++; $display("FAIL inv_refill_all_invalid: got %0d transfers, expected 4", nx); end
    endtask

    task automatic test_stalls();
        logic [31:0] d, a; int lat, nx; bit ok, exp_hit; int ic, line, tg;
        apply_reset();
        salt = $urandom;
        max_dly = 5;
        chk_stable = 1;
        for (int n = 0; n < 200; n++) begin
            a = 32'($urandom_range(0, 511)) << 2;
            ic = ($urandom_range(0, 15) == 0) ? 0 : -1;
            line = (a >> 4) & 15;
            tg = a >> 8;
            exp_hit = (ic != 0) && m_valid[line] && (m_tag[line] == tg);
            fetch(a, ic, d, lat, nx, ok);
            if (ic == 0) for (int i = 0; i < 16; i++) m_valid[i] = 0;
            m_valid[line] = 1;
            m_tag[line] = tg;
            checks++; if (d !== (a ^ salt)) begin errors++; $display("FAIL stall_data[%0d]: addr %h got %h, expected %h", n, a, d, a ^ salt); end
            checks++; if (nx != (exp_hit ? 0 : 4)) begin errors++; $display("FAIL stall_xfers[%0d]: addr %h got %0d, expected %0d", n, a, nx, exp_hit ? 0 : 4); end
            if (exp_hit) begin
                checks++; if (lat != 1) begin errors++; $display("FAIL stall_hit_latency[%0d]: got %0d, expected 1", n, lat); end
            end else if (nx == 4) begin
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if (xfer_q[i] !== ((a & ~32'hF) + 4*i)) begin errors++; $display("FAIL stall_mem_addr[%0d.%0d]: got %h, expected %h", n, i, xfer_q[i], (a & ~32'hF) + 4*i); end
                end
                checks++; if (valid_t - last_xfer_t != 5) begin errors++; $display("FAIL stall_resp_gap[%0d]: got %0t, expected 5", n, valid_t - last_xfer_t); end
            end
        end
        chk_stable = 0;
        max_dly = 0;
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] d; int lat, nx, cyc; bit ok;
        salt = 0;
        xfer_q.delete();
        @(negedge clk);
        exIns_ren = 1; exIns_addr = 32'h304;
        cyc = 0;
        while (xfer_q.size() < 2 && cyc < 100) begin @(negedge clk); cyc++; end
        checks++; if (xfer_q.size() != 2) begin errors++; $display("FAIL rstmid_two_xfers: got %0d, expected 2", xfer_q.size()); end
        rst = 1; exIns_ren = 0;
        @(negedge clk);
        rst = 0;
        checks++; if (mem_ren !== 1'b0) begin errors++; $display("FAIL rstmid_mem_ren: got %b, expected 0", mem_ren); end
        checks++; if (exIns_valid !== 1'b0) begin errors++; $display("FAIL rstmid_exIns_valid: got %b, expected 0", exIns_valid); end
        force_vld = 1;
        @(negedge clk);
        force_vld = 0;
        @(negedge clk);
        checks++; if (mem_ren !== 1'b0 || exIns_valid !== 1'b0) begin errors++; $display("FAIL rstmid_late_valid: got mem_ren=%b exIns_valid=%b, expected 0 0", mem_ren, exIns_valid); end
        fetch(32'h304, -1, d, lat, nx, ok);
        checks++; if (nx != 4) begin errors++; $display("FAIL rstmid_full_refill: got %0d transfers, expected 4", nx); end
        if (nx == 4) begin
            checks++; if (xfer_q[0] !== 32'h300 || xfer_q[3] !== 32'h30C) begin errors++; $display("FAIL rstmid_mem_addr: got %h..%h, expected 00000300..0000030c", xfer_q[0], xfer_q[3]); end
        end
        checks++; if (d !== 32'h304) begin errors++; $display("FAIL rstmid_data: got %h, expected 00000304", d); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_inv();
        test_reset_mid_refill();
        test_stalls();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache between the core's external instruction port (exIns_*) and the backing instruction memory. Hits answer one cycle after the request. Misses refill a whole line from memory, one word per transfer, and then return the requested word. A flush input invalidates all lines for fence.i and program reload.

## Interface
- LINES, 16, number of cache lines; must be a power of 2, at least 2.
- WORDS, 4, 32-bit words per line; must be a power of 2, at least 2.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- exIns_ren  in  1  core fetch request; the core holds it until exIns_valid.
- exIns_addr  in  32  fetch byte address; bits [1:0] are ignored.
- exIns_valid  out  1  one-cycle pulse: exIns_in holds the requested word.
- exIns_in  out  32  instruction word.
- inv  in  1  invalidate all lines.
- mem_ren  out  1  backing-memory word read request.
- mem_addr  out  32  word-aligned byte address; bits [1:0] are always 0.
- mem_valid  in  1  memory returns mem_rdata for the current mem_addr.
- mem_rdata  in  32  memory read data.

## Operation
- Address split:
  - offset = addr[2+log2(WORDS)-1:2]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage, all held in registers:
  - valid[LINES]
  - tag[LINES]
  - data[LINES][WORDS]
- State machine states: IDLE, REFILL, RESP.
- IDLE:
  - A request is accepted when exIns_ren=1 and exIns_valid=0. In a response cycle, exIns_ren is ignored; the core re-presents the next fetch.
  - On hit (valid and tag match), register the data word, pulse exIns_valid next cycle, stay in IDLE.
  - On miss, latch the address, set word counter k=0, go to REFILL.
- REFILL:
  - mem_ren=1 and mem_addr = line base + 4·k.
  - Each cycle with mem_ren & mem_valid writes mem_rdata into data[index][k] and increments k; mem_addr advances the next cycle.
  - After the transfer with k=WORDS-1: write the tag, set valid[index], drop mem_ren, go to RESP.
  - mem_valid with mem_ren=0 is ignored.
- RESP:
  - exIns_valid=1 and exIns_in = data[index][offset] of the latched address. Next state IDLE.
- Invalidate:
  - inv in IDLE or RESP clears all valid bits at the next edge.
  - A request accepted in the same IDLE cycle as inv is treated as a miss.
  - inv during REFILL sets inv_pend. When the refill completes, all valid bits are cleared and the just-refilled line is not marked valid. The requested word is still returned in RESP.
- Eviction: a miss overwrites the indexed line unconditionally. No write path exists.

## Timing
- Reset values: exIns_valid=0, exIns_in=0, mem_ren=0, mem_addr=0, all valid=0, inv_pend=0, state=IDLE, k=0. Tag and data arrays are not reset.
- Reset mid-refill: mem_ren=0 in the cycle after the reset edge. The partial line stays invalid, and a late mem_valid is ignored.
- Hit latency: request accepted at edge N, exIns_valid high in cycle N+1. Peak throughput is one word per 2 cycles.
- Miss latency: 1 cycle into REFILL, plus the sum of the WORDS memory transfer times, plus 1 RESP cycle. With zero-wait memory (mem_valid tied high), WORDS=4 gives exIns_valid 6 cycles after acceptance.
- mem_addr and mem_ren are registered. mem_addr is stable while mem_ren=1 and mem_valid=0.
- Refill order is always word 0 to word WORDS-1, independent of the missing offset.
- k wraps to 0 on refill completion. The word address inside a line wraps only at the line boundary, never across lines.

## Test plan
- **Cold miss** (LINES=16, WORDS=4, memory returns data = address): fetch 0x0000_0104.
  - Required: mem_addr sequence 0x100, 0x104, 0x108, 0x10C.
  - Then exIns_valid with exIns_in=0x104, 1 cycle after the last mem_valid.
- **Hit after refill**: fetch 0x0000_0108 after the cold-miss test.
  - Required: exIns_valid 1 cycle after acceptance, exIns_in=0x108, mem_ren stays 0.
- **Conflict eviction**:
  - Fetch 0x0000_0504 (index 0): refill 0x500–0x50C, exIns_in=0x504.
  - Then fetch 0x0000_0104: miss and refill again.
- **Invalidate**:
  - Pulse inv in IDLE, then fetch 0x0000_0108: required full miss and refill.
  - Pulse inv during REFILL: requested word still returned, then a re-fetch of the same line misses.
- **Memory stalls**: random 0–5 cycle mem_valid delays across 200 random fetches in 0x0–0x7FC, checked against a reference model.
  - Required: every exIns_in matches, and mem_addr never changes while mem_ren=1 and mem_valid=0.
- **Reset mid-refill**: assert rst after 2 of 4 transfers.
  - Required: mem_ren=0 and exIns_valid=0 the next cycle.
  - Re-fetch of the same line issues a full 4-word refill.
